// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg : default 640x480@60 timing constants and coordinate type     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Largest axis length a 10-bit coordinate can count through.
  localparam int MAX_TOTAL = 1024;

  typedef logic [9:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_axis_counter : wrap-at-TOTAL counter with registered sync decode  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
  parameter int SYNC_WIDTH = DEF_H_SYNC
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   advance,
  output coord_t count,
  output coord_t next_count,
  output logic   wrap,
  output logic   sync_n
);

  localparam coord_t      C_LAST    = coord_t'(TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 stays representable.
  localparam logic [10:0] C_SYNC_LO = 11'(SYNC_START);
  localparam logic [10:0] C_SYNC_HI = 11'(SYNC_START + SYNC_WIDTH);

  coord_t      r_count;
  logic        r_sync_n;
  logic [10:0] w_next_ext;

  always_comb begin
    wrap       = advance && (r_count == C_LAST);
    next_count = r_count;
    if (wrap) begin
      next_count = '0;
    end else if (advance) begin
      next_count = r_count + 10'd1;
    end
  end

  assign w_next_ext = {1'b0, next_count};

  // Sync is decoded from the next count so it moves on the same edge as the count.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_sync_n <= 1'b1;
    end else begin
      r_count  <= next_count;
      r_sync_n <= !((w_next_ext >= C_SYNC_LO) && (w_next_ext < C_SYNC_HI));
    end
  end

  assign count  = r_count;
  assign sync_n = r_sync_n;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen : 640x480@60 raster counters, syncs, blank, frame strobe|
// | Option VGA_SYNC_DELAY_EN: delay hs/vs one cycle behind the counters.  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] C_H_VISIBLE = 11'(H_VISIBLE);
  localparam logic [10:0] C_V_VISIBLE = 11'(V_VISIBLE);

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  coord_t w_h_next;
  coord_t w_v_next;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_hs;
  logic   w_vs;
  logic   r_blank;
  logic   r_frame_start;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_WIDTH (H_SYNC)
  ) u_h_axis (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .advance    (1'b1),
    .count      (DrawX),
    .next_count (w_h_next),
    .wrap       (w_h_wrap),
    .sync_n     (w_hs)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_WIDTH (V_SYNC)
  ) u_v_axis (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .advance    (w_h_wrap),
    .count      (DrawY),
    .next_count (w_v_next),
    .wrap       (w_v_wrap),
    .sync_n     (w_vs)
  );

  // The vertical wrap only fires on a horizontal wrap, so it marks the (0,0) edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_blank       <= ({1'b0, w_h_next} < C_H_VISIBLE) && ({1'b0, w_v_next} < C_V_VISIBLE);
      r_frame_start <= w_v_wrap;
    end
  end

  assign blank       = r_blank;
  assign frame_start = r_frame_start;

`ifdef VGA_SYNC_DELAY_EN
  logic r_hs_dly;
  logic r_vs_dly;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_dly <= 1'b1;
      r_vs_dly <= 1'b1;
    end else begin
      r_hs_dly <= w_hs;
      r_vs_dly <= w_vs;
    end
  end

  assign hs = r_hs_dly;
  assign vs = r_vs_dly;
`else
  assign hs = w_hs;
  assign vs = w_vs;
`endif

endmodule
`default_nettype wire
